// File: rtl/midi_rx_if.sv
// midi_rx_if: bundle between a MIDI serial source and the midi_rx receiver.
//   rx        : serial MIDI line, idles high
//   note      : held-key vector, bit i = key BASE_KEY+i
//   msg_valid : one-cycle pulse per parsed note message
//   msg_on    : 1 = note on, 0 = note off (meaningful while msg_valid)
//   msg_key   : key number of the last note message
//   msg_vel   : velocity of the last note message
//   prog      : last Program Change value
//   frame_err : one-cycle pulse when a stop bit samples low
`timescale 1ns/1ps
interface midi_rx_if;
   logic       rx;
   logic [9:0] note;
   logic       msg_valid;
   logic       msg_on;
   logic [6:0] msg_key;
   logic [6:0] msg_vel;
   logic [6:0] prog;
   logic       frame_err;

   // Line driver / observer side.
   modport master (
      output rx,
      input  note, msg_valid, msg_on, msg_key, msg_vel, prog, frame_err
   );

   // Receiver side.
   modport slave (
      input  rx,
      output note, msg_valid, msg_on, msg_key, msg_vel, prog, frame_err
   );
endinterface

// File: rtl/midi_rx.sv
// midi_rx: 8N1 MIDI receiver with a Note On / Note Off / Program Change parser.
// Keeps a 10-key held-note vector so an external keyboard can stand in for the
// on-board keys.
//   clk_i  : system clock
//   rst_ni : synchronous reset, active low
//   bus    : midi_rx_if.slave (rx in; note, msg_*, prog, frame_err out)
`timescale 1ns/1ps
module midi_rx #(
   parameter int unsigned CLK_HZ   = 100000000,
   parameter int unsigned BAUD     = 31250,
   parameter int unsigned BASE_KEY = 60,
   parameter int unsigned CHANNEL  = 16 // 16 = omni
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   midi_rx_if.slave bus
);

   localparam int unsigned DIV  = CLK_HZ / BAUD;
   localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] DivM1   = CntW'(DIV - 1);
   localparam logic [CntW-1:0] HalfM1  = CntW'(DIV / 2 - 1);
   localparam logic [7:0]      BaseKey = 8'(BASE_KEY);
   localparam logic [3:0]      Chan    = 4'(CHANNEL);
   localparam bit              Omni    = (CHANNEL == 16);

   // ---------------------------------------------------------------- sync
   logic rx_meta_q, rxs_q, rxs_prev_q, rx_fall;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         rx_meta_q  <= bus.rx;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
      end
   end

   assign rx_fall = rxs_prev_q & ~rxs_q;

   // -------------------------------------------------------- bit receiver
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

   rx_state_e       st_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      idx_q;
   logic [7:0]      byte_q;
   logic            byte_rdy_q;
   logic            frame_err_q;
   logic            stop_wait_q; // bad stop seen, waiting for the line to go high

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         st_q        <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         byte_q      <= '0;
         byte_rdy_q  <= 1'b0;
         frame_err_q <= 1'b0;
         stop_wait_q <= 1'b0;
      end else begin
         byte_rdy_q  <= 1'b0;
         frame_err_q <= 1'b0;
         unique case (st_q)
            StIdle: begin
               if (rx_fall) begin
                  cnt_q <= HalfM1;
                  st_q  <= StStart;
               end
            end
            StStart: begin
               if (cnt_q == '0) begin
                  if (rxs_q) begin
                     st_q <= StIdle; // glitch, not a start bit
                  end else begin
                     cnt_q <= DivM1;
                     idx_q <= '0;
                     st_q  <= StData;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StData: begin
               if (cnt_q == '0) begin
                  byte_q <= {rxs_q, byte_q[7:1]}; // LSB first
                  cnt_q  <= DivM1;
                  if (idx_q == 3'd7) begin
                     st_q <= StStop;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StStop: begin
               if (stop_wait_q) begin
                  if (rxs_q) begin
                     stop_wait_q <= 1'b0;
                     st_q        <= StIdle;
                  end
               end else if (cnt_q == '0) begin
                  if (rxs_q) begin
                     byte_rdy_q <= 1'b1;
                     st_q       <= StIdle;
                  end else begin
                     frame_err_q <= 1'b1;
                     stop_wait_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   // -------------------------------------------------------------- parser
   logic [7:0] rs_q, rs_d;     // running status, 0 = none
   logic       dcnt_q, dcnt_d; // 1 once the first of two data bytes is held
   logic [6:0] key_q, key_d;
   logic [9:0] note_q, note_d;
   logic       msg_valid_q, msg_valid_d;
   logic       msg_on_q, msg_on_d;
   logic [6:0] msg_key_q, msg_key_d;
   logic [6:0] msg_vel_q, msg_vel_d;
   logic [6:0] prog_q, prog_d;

   logic       one_byte, note_msg, prog_msg, chan_ok;
   logic [7:0] key_idx;

   assign one_byte = (rs_q[6:5] == 2'b10);   // Cx / Dx
   assign note_msg = (rs_q[7:5] == 3'b100);  // 8x / 9x
   assign prog_msg = (rs_q[7:4] == 4'hC);
   assign chan_ok  = Omni || (rs_q[3:0] == Chan);
   assign key_idx  = {1'b0, key_q} - BaseKey; // wraps high when below BaseKey

   always_comb begin
      rs_d        = rs_q;
      dcnt_d      = dcnt_q;
      key_d       = key_q;
      note_d      = note_q;
      msg_valid_d = 1'b0;
      msg_on_d    = msg_on_q;
      msg_key_d   = msg_key_q;
      msg_vel_d   = msg_vel_q;
      prog_d      = prog_q;
      if (byte_rdy_q) begin
         if (byte_q[7]) begin
            // Realtime bytes (F8-FF) leave everything untouched.
            if (byte_q[7:3] != 5'b11111) begin
               rs_d   = (byte_q[7:4] == 4'hF) ? 8'h00 : byte_q;
               dcnt_d = 1'b0;
            end
         end else if (rs_q[7]) begin
            if (!one_byte && !dcnt_q) begin
               key_d  = byte_q[6:0];
               dcnt_d = 1'b1;
            end else begin
               dcnt_d = 1'b0;
               if (prog_msg && chan_ok) begin
                  prog_d = byte_q[6:0];
               end
               if (note_msg && chan_ok) begin
                  msg_valid_d = 1'b1;
                  msg_on_d    = rs_q[4] && (byte_q[6:0] != 7'd0);
                  msg_key_d   = key_q;
                  msg_vel_d   = byte_q[6:0];
                  if (key_idx < 8'd10) begin
                     note_d[key_idx[3:0]] = msg_on_d;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rs_q        <= '0;
         dcnt_q      <= 1'b0;
         key_q       <= '0;
         note_q      <= '0;
         msg_valid_q <= 1'b0;
         msg_on_q    <= 1'b0;
         msg_key_q   <= '0;
         msg_vel_q   <= '0;
         prog_q      <= '0;
      end else begin
         rs_q        <= rs_d;
         dcnt_q      <= dcnt_d;
         key_q       <= key_d;
         note_q      <= note_d;
         msg_valid_q <= msg_valid_d;
         msg_on_q    <= msg_on_d;
         msg_key_q   <= msg_key_d;
         msg_vel_q   <= msg_vel_d;
         prog_q      <= prog_d;
      end
   end

   assign bus.note      = note_q;
   assign bus.msg_valid = msg_valid_q;
   assign bus.msg_on    = msg_on_q;
   assign bus.msg_key   = msg_key_q;
   assign bus.msg_vel   = msg_vel_q;
   assign bus.prog      = prog_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_midi_rx.sv
// tb_midi_rx: drives one serial line into an omni receiver and a channel-0
// receiver, predicts their outputs from a byte-level message model and
// compares every cycle.
`timescale 1ns/1ps
module tb_midi_rx;
   localparam int unsigned CLK_HZ = 3200;
   localparam int unsigned BAUD   = 100;
   localparam int          DIV    = CLK_HZ / BAUD; // 32 cycles per bit
   localparam int          BASE   = 60;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic rx_line = 1'b1;
   int   cyc     = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   midi_rx_if bus0 ();
   midi_rx_if bus1 ();
   assign bus0.rx = rx_line;
   assign bus1.rx = rx_line;

   midi_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE_KEY(BASE), .CHANNEL(16)) dut_omni (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus0)
   );

   midi_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE_KEY(BASE), .CHANNEL(0)) dut_ch0 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus1)
   );

   // ------------------------------------------------------------ model
   int          chan [2] = '{16, 0};
   logic [7:0]  m_rs [2];
   int          m_cnt [2];
   logic [6:0]  m_d0 [2];
   logic [9:0]  m_note [2];
   logic [6:0]  m_key [2];
   logic [6:0]  m_vel [2];
   logic [6:0]  m_prog [2];
   int          ferr_pend [2];
   int          mv_cnt [2];
   int          fe_cnt [2];
   logic [14:0] evq0 [$];
   logic [14:0] evq1 [$];
   bit          settled = 1'b0;
   int          byte_start = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input int d, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, d, act, act, exp, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_rs[d]      = 8'h00;
         m_cnt[d]     = 0;
         m_d0[d]      = 7'd0;
         m_note[d]    = 10'd0;
         m_key[d]     = 7'd0;
         m_vel[d]     = 7'd0;
         m_prog[d]    = 7'd0;
         ferr_pend[d] = 0;
      end
      evq0.delete();
      evq1.delete();
   endtask

   // Apply one correctly framed byte to both receivers' expected state.
   task automatic model_byte(input logic [7:0] b);
      for (int d = 0; d < 2; d++) begin
         int         hi;
         int         k;
         bit         trk;
         bit         on;
         logic [7:0] rs;
         rs = m_rs[d];
         hi = int'(rs) / 16;
         if (b >= 8'hF8) continue;
         if (b >= 8'hF0) begin
            m_rs[d] = 8'h00;
            continue;
         end
         if (b >= 8'h80) begin
            m_rs[d]  = b;
            m_cnt[d] = 0;
            continue;
         end
         if (rs == 8'h00) continue;
         trk = (hi == 8 || hi == 9 || hi == 12) &&
               (chan[d] == 16 || chan[d] == int'(rs) % 16);
         if (hi == 12 || hi == 13) begin
            if (trk) m_prog[d] = b[6:0];
            m_cnt[d] = 0;
         end else if (m_cnt[d] == 0) begin
            m_d0[d]  = b[6:0];
            m_cnt[d] = 1;
         end else begin
            m_cnt[d] = 0;
            if (trk) begin
               on       = (hi == 9) && (b != 8'h00);
               m_key[d] = m_d0[d];
               m_vel[d] = b[6:0];
               if (d == 0) evq0.push_back({on, m_d0[d], b[6:0]});
               else        evq1.push_back({on, m_d0[d], b[6:0]});
               k = int'(m_d0[d]) - BASE;
               if (k >= 0 && k < 10) m_note[d][k] = on;
            end
         end
      end
   endtask

   // ---------------------------------------------------------- compare
   task automatic observe(input int d, input logic mv, input logic on,
                          input logic [6:0] key, input logic [6:0] vel, input logic fe,
                          input logic [9:0] note, input logic [6:0] prog);
      logic [14:0] e;
      int          qn;
      int          lat;
      qn = (d == 0) ? evq0.size() : evq1.size();
      if (mv) begin
         mv_cnt[d]++;
         if (qn == 0) begin
            chk("msg_valid with no message due", d, int'(mv), 0);
         end else begin
            if (d == 0) e = evq0.pop_front();
            else        e = evq1.pop_front();
            lat = cyc - byte_start;
            chk("msg_on", d, int'(on), int'(e[14]));
            chk("msg_key", d, int'(key), int'(e[13:7]));
            chk("msg_vel", d, int'(vel), int'(e[6:0]));
            chk("msg latency in window", d, int'(lat >= DIV * 19 / 2 && lat < DIV * 10), 1);
         end
      end
      if (fe) begin
         fe_cnt[d]++;
         chk("frame_err expected", d, int'(ferr_pend[d] > 0), 1);
         if (ferr_pend[d] > 0) ferr_pend[d]--;
      end
      if (settled) begin
         chk("note", d, int'(note), int'(m_note[d]));
         chk("msg_key idle", d, int'(key), int'(m_key[d]));
         chk("msg_vel idle", d, int'(vel), int'(m_vel[d]));
         chk("prog", d, int'(prog), int'(m_prog[d]));
         chk("messages still due", d, qn, 0);
         chk("frame errors still due", d, ferr_pend[d], 0);
         chk("msg_valid idle", d, int'(mv), 0);
         chk("frame_err idle", d, int'(fe), 0);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         observe(0, bus0.msg_valid, bus0.msg_on, bus0.msg_key, bus0.msg_vel,
                 bus0.frame_err, bus0.note, bus0.prog);
         observe(1, bus1.msg_valid, bus1.msg_on, bus1.msg_key, bus1.msg_vel,
                 bus1.frame_err, bus1.note, bus1.prog);
      end
   end

   // --------------------------------------------------------- stimulus
   task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1,
                            input int gap = 24);
      settled    = 1'b0;
      byte_start = cyc;
      rx_line    = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx_line = good_stop;
      if (good_stop) begin
         model_byte(b);
      end else begin
         ferr_pend[0]++;
         ferr_pend[1]++;
      end
      repeat (DIV) @(negedge clk);
      rx_line = 1'b1;
      repeat (6) @(negedge clk);
      settled = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic glitch(input int len);
      settled = 1'b0;
      rx_line = 1'b0;
      repeat (len) @(negedge clk);
      rx_line = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      settled = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      int m0, m1, f0;
      model_reset();
      for (int d = 0; d < 2; d++) begin
         mv_cnt[d] = 0;
         fe_cnt[d] = 0;
      end
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      chk("reset note", 0, int'(bus0.note), 0);
      chk("reset msg_valid", 0, int'(bus0.msg_valid), 0);
      chk("reset msg_key", 0, int'(bus0.msg_key), 0);
      chk("reset prog", 0, int'(bus0.prog), 0);
      chk("reset frame_err", 1, int'(bus1.frame_err), 0);
      rst_n = 1'b1;
      repeat (DIV) @(negedge clk);

      // Lone status byte, then a note on / note off pair.
      send_byte(8'h90);
      send_byte(8'h3C);
      send_byte(8'h64);
      chk("lit note on", 0, int'(bus0.note), 10'b0000000001);
      chk("lit key 60", 0, int'(bus0.msg_key), 60);
      chk("lit vel 100", 0, int'(bus0.msg_vel), 100);
      send_byte(8'h80);
      send_byte(8'h3C);
      send_byte(8'h00);
      chk("lit note off", 0, int'(bus0.note), 0);

      // Running status with velocity-0 off on channel 1.
      m0 = mv_cnt[0];
      m1 = mv_cnt[1];
      send_byte(8'h91);
      send_byte(8'h3E);
      send_byte(8'h40);
      send_byte(8'h45);
      send_byte(8'h40);
      send_byte(8'h3E);
      send_byte(8'h00);
      chk("lit running status note", 0, int'(bus0.note), 10'b1000000000);
      chk("lit channel-filtered note", 1, int'(bus1.note), 0);
      chk("lit omni pulses", 0, mv_cnt[0] - m0, 3);
      chk("lit ch0 pulses", 1, mv_cnt[1] - m1, 0);

      // Clock byte mid-message, then a system byte kills running status.
      send_byte(8'h90);
      send_byte(8'h3D);
      send_byte(8'hF8);
      send_byte(8'h7F);
      chk("lit realtime transparent", 0, int'(bus0.note), 10'b1000000010);
      send_byte(8'hF0);
      send_byte(8'h3D);
      send_byte(8'h00);
      chk("lit system clears status", 0, int'(bus0.note), 10'b1000000010);

      // Program change and an out-of-range key.
      send_byte(8'hC0);
      send_byte(8'h05);
      chk("lit program", 0, int'(bus0.prog), 5);
      chk("lit program ch0", 1, int'(bus1.prog), 5);
      send_byte(8'h90);
      send_byte(8'h30);
      send_byte(8'h40);
      chk("lit key 48", 0, int'(bus0.msg_key), 48);
      chk("lit out-of-range note", 0, int'(bus0.note), 10'b1000000010);

      // Framing error and a short glitch.
      f0 = fe_cnt[0];
      send_byte(8'h55, 1'b0);
      chk("lit frame_err pulses", 0, fe_cnt[0] - f0, 1);
      glitch(10);

      // Reset in the middle of a byte with keys held.
      settled    = 1'b0;
      byte_start = cyc;
      rx_line    = 1'b0;
      repeat (DIV) @(negedge clk);
      rx_line = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid-byte reset note", 0, int'(bus0.note), 0);
      chk("mid-byte reset key", 0, int'(bus0.msg_key), 0);
      chk("mid-byte reset vel", 0, int'(bus0.msg_vel), 0);
      chk("mid-byte reset prog", 0, int'(bus0.prog), 0);
      chk("mid-byte reset msg_on", 0, int'(bus0.msg_on), 0);
      model_reset();
      rst_n = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      send_byte(8'h90);
      send_byte(8'h41);
      send_byte(8'h50);
      chk("lit note after reset", 0, int'(bus0.note), 10'b0000100000);
      chk("lit note after reset ch0", 1, int'(bus1.note), 10'b0000100000);

      // Randomised byte stream.
      for (int i = 0; i < 60; i++) begin
         int         r;
         int         sel;
         logic [7:0] b;
         r = $urandom_range(0, 99);
         if (r < 24) begin
            b = {4'(8 + $urandom_range(0, 6)), 4'($urandom_range(0, 2))};
            send_byte(b);
         end else if (r < 78) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      b = 8'h00;
            else if (sel == 1) b = 8'($urandom_range(56, 73));
            else               b = 8'($urandom_range(0, 127));
            send_byte(b);
         end else if (r < 86) begin
            send_byte(8'hF8 + 8'($urandom_range(0, 7)));
         end else if (r < 90) begin
            send_byte(8'hF0 + 8'($urandom_range(0, 7)));
         end else if (r < 96) begin
            send_byte(8'($urandom_range(0, 255)), 1'b0);
         end else begin
            glitch($urandom_range(2, DIV / 2 - 4));
         end
      end

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
